// File: rtl/seg_disp_arbiter.sv
// rtl/seg_disp_arbiter.sv - four-way dwell-limited arbiter driving a two-digit seven-segment display
// Optional ARB_FIXED_PRIO_EN: lowest-index fixed priority replaces the round-robin pointer.
module seg_disp_arbiter #(
  parameter logic [25:0] DWELL   = 26'd50_000_000,
  parameter logic [15:0] REFRESH = 16'd50_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [31:0] data,
  input  logic        freeze,
  output logic [3:0]  grant,
  output logic [1:0]  index,
  output logic [7:0]  num,
  output logic        busy,
  output logic [6:0]  light,
  output logic [1:0]  com
);

  typedef enum logic {S_IDLE = 1'b0, S_OWN = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [3:0]  grant_q, grant_d;
  logic [1:0]  index_q, index_d;
  logic [7:0]  num_q, num_d;
  logic [25:0] dwell_q, dwell_d;
  logic [15:0] ref_q;
  logic        sel_q;
  logic [6:0]  light_q, light_d;
  logic [1:0]  com_q, com_d;
  logic        take;
  logic        cand_any;
  logic [1:0]  cand_idx;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0:    hex7 = 7'h40;
      4'h1:    hex7 = 7'h79;
      4'h2:    hex7 = 7'h24;
      4'h3:    hex7 = 7'h30;
      4'h4:    hex7 = 7'h19;
      4'h5:    hex7 = 7'h12;
      4'h6:    hex7 = 7'h02;
      4'h7:    hex7 = 7'h78;
      4'h8:    hex7 = 7'h00;
      4'h9:    hex7 = 7'h10;
      4'hA:    hex7 = 7'h08;
      4'hB:    hex7 = 7'h03;
      4'hC:    hex7 = 7'h46;
      4'hD:    hex7 = 7'h21;
      4'hE:    hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

`ifdef ARB_FIXED_PRIO_EN
  // Owner stays a candidate so expiry only hands over when a lower index is waiting.
  always_comb begin
    cand_any = |req;
    cand_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (req[i]) cand_idx = 2'(i);
    end
  end
`else
  logic [1:0] ptr_q;
  logic [3:0] rr_req;

  // Owner is masked out, so any candidate is always a different source.
  assign rr_req = req & ~grant_q;

  always_comb begin
    cand_any = |rr_req;
    cand_idx = ptr_q;
    for (int k = 4; k >= 1; k--) begin
      if (rr_req[ptr_q + 2'(k)]) cand_idx = ptr_q + 2'(k);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    dwell_d = dwell_q;
    unique case (state_q)
      S_IDLE: begin
        if (cand_any) begin
          state_d = S_OWN;
          take    = 1'b1;
        end
      end
      S_OWN: begin
        if ((req & grant_q) == 4'b0000) begin
          if (cand_any) take    = 1'b1;
          else          state_d = S_IDLE;
        end else if (!freeze) begin
          if (dwell_q == 26'd0) begin
            if (cand_any && (cand_idx != index_q)) take    = 1'b1;
            else                                   dwell_d = DWELL - 26'd1;
          end else begin
            dwell_d = dwell_q - 26'd1;
          end
        end
      end
    endcase
    if (take) dwell_d = DWELL - 26'd1;
  end

  always_comb begin
    grant_d = grant_q;
    index_d = index_q;
    num_d   = num_q;
    if (take) begin
      grant_d = 4'b0001 << cand_idx;
      index_d = cand_idx;
      num_d   = data[{cand_idx, 3'b000} +: 8];
    end else if (state_d == S_IDLE) begin
      grant_d = 4'b0000;
    end else begin
      num_d   = data[{index_q, 3'b000} +: 8];
    end

    light_d = 7'h7F;
    com_d   = 2'b11;
    if (state_q == S_OWN) begin
      light_d = hex7(sel_q ? num_q[7:4] : num_q[3:0]);
      com_d   = sel_q ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q <= 4'b0000;
      index_q <= 2'd0;
      num_q   <= 8'h00;
      dwell_q <= 26'd0;
      ref_q   <= 16'd0;
      sel_q   <= 1'b0;
      light_q <= 7'h7F;
      com_q   <= 2'b11;
`ifndef ARB_FIXED_PRIO_EN
      ptr_q   <= 2'd3;
`endif
    end else begin
      grant_q <= grant_d;
      index_q <= index_d;
      num_q   <= num_d;
      dwell_q <= dwell_d;
      light_q <= light_d;
      com_q   <= com_d;
      if (ref_q == REFRESH - 16'd1) begin
        ref_q <= 16'd0;
        sel_q <= ~sel_q;
      end else begin
        ref_q <= ref_q + 16'd1;
      end
`ifndef ARB_FIXED_PRIO_EN
      if (take) ptr_q <= cand_idx;
`endif
    end
  end

  assign grant = grant_q;
  assign index = index_q;
  assign num   = num_q;
  assign busy  = (state_q == S_OWN);
  assign light = light_q;
  assign com   = com_q;

endmodule

// File: tb/tb_seg_disp_arbiter.sv
// tb/tb_seg_disp_arbiter.sv - scoreboard bench for seg_disp_arbiter against a cycle-level reference model
module tb_seg_disp_arbiter;

  localparam logic [25:0] DW = 26'd8;
  localparam logic [15:0] RF = 16'd4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = 4'h0;
  logic [31:0] data = 32'h3CA5_9612;
  logic        freeze = 1'b0;
  logic [3:0]  grant;
  logic [1:0]  index;
  logic [7:0]  num;
  logic        busy;
  logic [6:0]  light;
  logic [1:0]  com;

  seg_disp_arbiter #(.DWELL(DW), .REFRESH(RF)) dut (
    .clk(clk), .rst(rst), .req(req), .data(data), .freeze(freeze),
    .grant(grant), .index(index), .num(num), .busy(busy), .light(light), .com(com)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] grant;
    logic [1:0] index;
    logic [7:0] num;
    logic       busy;
    logic [6:0] light;
    logic [1:0] com;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference state: owner -1 means idle; remain is cycles left before dwell expiry.
  int         m_owner = -1;
  int         m_remain = 0;
  int         m_last = 3;
  int         m_idx = 0;
  int         m_sel = 0;
  int         m_ref = 0;
  logic [7:0] m_num = 8'h00;
  logic [6:0] m_light = 7'h7F;
  logic [1:0] m_com = 2'b11;

  function automatic int pick_rr(input logic [3:0] r, input int base);
    for (int k = 1; k <= 4; k++) begin
      if (r[(base + k) % 4]) return (base + k) % 4;
    end
    return -1;
  endfunction

  function automatic int pick_fixed(input logic [3:0] r);
    for (int i = 0; i < 4; i++) begin
      if (r[i]) return i;
    end
    return -1;
  endfunction

  function automatic int arb_any(input logic [3:0] r);
`ifdef ARB_FIXED_PRIO_EN
    return pick_fixed(r);
`else
    return pick_rr(r, m_last);
`endif
  endfunction

  function automatic int arb_expiry(input logic [3:0] r);
    int w;
`ifdef ARB_FIXED_PRIO_EN
    w = pick_fixed(r);
    if (w == m_owner) w = -1;
`else
    w = pick_rr(r & ~(4'b0001 << m_owner), m_owner);
`endif
    return w;
  endfunction

  task automatic give(input int w, input logic [31:0] d);
    m_owner  = w;
    m_last   = w;
    m_idx    = w;
    m_remain = int'(DW) - 1;
    m_num    = d[8*w +: 8];
  endtask

  task automatic model_step(input logic r, input logic [3:0] q, input logic f, input logic [31:0] d);
    int   w;
    exp_t e;
    if (r) begin
      m_owner = -1; m_remain = 0; m_last = 3; m_idx = 0; m_sel = 0; m_ref = 0;
      m_num = 8'h00; m_light = 7'h7F; m_com = 2'b11;
    end else begin
      if (m_owner >= 0) begin
        m_light = hex_tab[m_sel != 0 ? m_num[7:4] : m_num[3:0]];
        m_com   = (m_sel != 0) ? 2'b01 : 2'b10;
      end else begin
        m_light = 7'h7F;
        m_com   = 2'b11;
      end
      if (m_ref == int'(RF) - 1) begin
        m_ref = 0;
        m_sel = 1 - m_sel;
      end else begin
        m_ref++;
      end
      if (m_owner < 0) begin
        w = arb_any(q);
        if (w >= 0) give(w, d);
      end else if (!q[m_owner]) begin
        w = arb_any(q);
        if (w >= 0) give(w, d);
        else        m_owner = -1;
      end else if (f) begin
        m_num = d[8*m_owner +: 8];
      end else if (m_remain == 0) begin
        w = arb_expiry(q);
        if (w >= 0) give(w, d);
        else begin
          m_remain = int'(DW) - 1;
          m_num    = d[8*m_owner +: 8];
        end
      end else begin
        m_remain--;
        m_num = d[8*m_owner +: 8];
      end
    end
    e.grant = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
    e.index = 2'(m_idx);
    e.num   = m_num;
    e.busy  = (m_owner >= 0);
    e.light = m_light;
    e.com   = m_com;
    sbq.push_back(e);
  endtask

  task automatic cyc(input logic r, input logic [3:0] q, input logic f, input logic [31:0] d);
    @(negedge clk);
    #1;
    rst = r; req = q; freeze = f; data = d;
    model_step(r, q, f, d);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor fires on the falling edge, ahead of the driver's #1, so it only sees settled entries.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("grant", 32'(grant), 32'(e.grant));
        chk("index", 32'(index), 32'(e.index));
        chk("num",   32'(num),   32'(e.num));
        chk("busy",  32'(busy),  32'(e.busy));
        chk("light", 32'(light), 32'(e.light));
        chk("com",   32'(com),   32'(e.com));
      end
    end
  end

  initial begin
    logic [31:0] pd;
    logic [3:0]  rq;
    logic        fz;
    pd = 32'h3CA5_9612;

    repeat (3) cyc(1'b1, 4'hF, 1'b0, pd);
    repeat (45) cyc(1'b0, 4'hF, 1'b0, pd);

    repeat (3) cyc(1'b0, 4'h0, 1'b0, pd);
    repeat (3) cyc(1'b0, 4'h1, 1'b0, pd);
    repeat (5) cyc(1'b0, 4'h4, 1'b0, pd);
    repeat (6) cyc(1'b0, 4'h0, 1'b0, pd);

    cyc(1'b0, 4'h3, 1'b0, pd);
    repeat (20) cyc(1'b0, 4'h3, 1'b1, pd);
    repeat (15) cyc(1'b0, 4'h3, 1'b0, pd);
    repeat (3) cyc(1'b0, 4'h0, 1'b0, pd);

    repeat (20) cyc(1'b0, 4'h2, 1'b0, pd);
    repeat (2) cyc(1'b0, 4'h0, 1'b0, pd);

    repeat (5) cyc(1'b0, 4'hA, 1'b0, pd);
    repeat (12) cyc(1'b0, 4'h8, 1'b0, pd);

    repeat (4) cyc(1'b0, 4'hF, 1'b0, pd);
    cyc(1'b1, 4'hF, 1'b0, pd);
    repeat (6) cyc(1'b0, 4'hF, 1'b0, pd);

    rq = 4'h0;
    fz = 1'b0;
    for (int n = 0; n < 800; n++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(7) == 0) rq[b] = ~rq[b];
      end
      if ($urandom_range(15) == 0) fz = ~fz;
      cyc(($urandom_range(299) == 0), rq, fz, $urandom);
    end

    repeat (3) @(negedge clk);
    #2;
    chk("drain", 32'(sbq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seg_disp_arbiter.md
Name: seg_disp_arbiter

Overview:
- Shares the board's two-digit seven-segment display between four requesters, each presenting one byte.
- Round-robin arbiter with a minimum dwell time per grant and a freeze input.
- Registers the winning byte and multiplexes it onto the two digits with hex decode.
- Sits between the datapath producers and the display pins; replaces direct, unarbitrated drive of light/com.

Parameters:
DWELL, 26'd50_000_000, minimum cycles a grantee owns the display (≥2); counter width 26 bits
REFRESH, 16'd50_000, cycles each digit stays enabled before the multiplexer toggles (≥1)

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
req  input  4  request per source; level, held while source wants the display
data  input  32  packed bytes; source i byte = data[8i+7:8i]
freeze  input  1  level; holds current grant and pauses dwell countdown
grant  output  4  one-hot grant, all-zero when idle
index  output  2  binary index of grantee; holds last value when idle
num  output  8  registered byte currently displayed
busy  output  1  high while any grant is active
light  output  7  segments a..g on [0]..[6], active-low (0 = lit)
com  output  2  digit enables, active-low; com[0] = low nibble digit, com[1] = high nibble digit

Behaviour:
- Reset values: grant 4'b0000, index 2'd0, num 8'h00, busy 0, light 7'h7F, com 2'b11. Dwell counter 0, refresh counter 0, digit select 0. Round-robin pointer favours req[0] first.
- States:
  - IDLE: no grant. Registered arbitration on any req bit. Next cycle: state OWN, grant/index/num/busy updated together, dwell counter loaded with DWELL-1. One-cycle grant latency.
  - OWN: num tracks data byte of grantee every cycle (live update). Dwell counter decrements by 1 per cycle unless freeze = 1.
- Release rules in OWN, evaluated per cycle with this priority:
  - Owner req drops (regardless of freeze or dwell): next cycle re-arbitrate among remaining req. None remain → IDLE (grant 0, busy 0, num holds last value, light blank, com 2'b11).
  - freeze = 1: hold grant; counter holds.
  - Counter = 0 and another req active: hand over to next requester in round-robin order after the current owner; counter reloads DWELL-1. No idle gap; handover takes exactly one cycle.
  - Counter = 0 and only the owner requesting: keep grant, reload counter.
- Round-robin search order: owner+1, owner+2, owner+3 (mod 4); pointer advances only on a grant.
- Simultaneous owner-drop and dwell expiry: treat as owner-drop.
- Requests arriving mid-dwell wait; no preemption.
- Display multiplexing:
  - Refresh counter counts 0..REFRESH-1, wraps, and toggles digit select on wrap.
  - Runs in all states.
  - In IDLE, com = 2'b11 and light = 7'h7F.
  - In OWN: digit select 0 → com 2'b10, light = hex(num[3:0]); select 1 → com 2'b01, light = hex(num[7:4]).
  - light and com are registered, one cycle after num/select.
- Hex decode, active-low, gfedcba:
  - 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78
  - 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E
- rst asserted mid-grant: next edge returns all outputs to reset values; no partial handover.

Optional Feature:
ARB_FIXED_PRIO_EN
- Defined: every arbitration picks the lowest-indexed active req; the pointer is removed.
- Dwell expiry with a lower-indexed req active hands over to it. With only higher-indexed reqs active, the owner keeps the grant while requesting.
- Undefined: round-robin as specified.

Test Plan (DWELL=8, REFRESH=4, data=32'h3C_A5_96_12):
- Reset: hold rst 3 cycles with req=4'hF → grant 0, num 00, light 7F, com 11, busy 0. Release rst → grant 0001, index 0, num 12 one cycle later.
- Rotation: req=4'hF held → grants 0001, 0010, 0100, 1000, 0001, each lasting exactly 8 cycles, back-to-back; num sequence 12, 96, A5, 3C.
- Early release: req0 alone granted, drop req0 at dwell cycle 3 with req2 high → grant 0100 next cycle, num A5. Drop all → IDLE, busy 0, com 11.
- Freeze: req=4'h3, owner 0, assert freeze 20 cycles → grant stays 0001 for 20 + 8 cycles total, then 0010.
- Display: owner 1 (num 96) → com alternates 10/01 every 4 cycles; light 02 with com 10 and 10 with com 01.
- With ARB_FIXED_PRIO_EN: req=4'hA → grant 0010 held while req1 high, with no rotation to bit 3. Drop req1 → 1000.
